pixel_scan_reader: RTL and testbench

PIXEL_SCAN_READER -- requirements
Module: pixel_scan_reader

---
 rtl/pixel_scan_reader_if.sv | 15 +
 rtl/pixel_scan_reader.sv | 119 +++++++++++
 tb/tb_pixel_scan_reader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_scan_reader_if.sv
// Canvas read bus between the scan reader and the canvas memory.
//   XRead/YRead     : canvas column/row the reader wants next
//   readValueMemory : pixel code returned by the memory, valid 1 clk after
//                     the address changes
// master = scan reader side, slave = memory side.
interface pixel_scan_reader_if #(
   parameter int ColorBits = 3
);
   logic [8:0]           XRead;
   logic [7:0]           YRead;
   logic [ColorBits-1:0] readValueMemory;

   modport master (output XRead, output YRead, input readValueMemory);
   modport slave  (input XRead, input YRead, output readValueMemory);
endinterface

// File: rtl/pixel_scan_reader.sv
// Scans a half-resolution canvas and produces VGA timing and colour.
// Pixel clock is clk/2: a phase flop toggles every clk and every second edge
// is a pixel tick. A two-stage pipeline issues the canvas address (stage 1)
// and registers the returned pixel plus the delayed sync/visible flags
// (stage 2), so all video outputs lag the scan counters by two ticks and
// change only on the edge where clkVGA falls.
// Ports:
//   clk, reset       : system clock, async active-low reset
//   mem              : canvas read bus (XRead, YRead out; readValueMemory in)
//   hsync, vsync     : active-low sync pulses
//   red/green/blue   : 8-bit DAC data, full-scale or zero per colour bit
//   blank            : 1 only for visible pixels
//   clkVGA           : pixel clock (clk/2)
//   frame_start      : 1-clk pulse when the scan wraps to (0,0)
module pixel_scan_reader #(
   parameter int ColorBits = 3,
   parameter int HVisible  = 640,
   parameter int HFront    = 16,
   parameter int HSync     = 96,
   parameter int HBack     = 48,
   parameter int VVisible  = 480,
   parameter int VFront    = 10,
   parameter int VSync     = 2,
   parameter int VBack     = 33
) (
   input  logic                       clk,
   input  logic                       reset,
   pixel_scan_reader_if.master        mem,
   output logic                       hsync,
   output logic                       vsync,
   output logic [7:0]                 red,
   output logic [7:0]                 green,
   output logic [7:0]                 blue,
   output logic                       blank,
   output logic                       clkVGA,
   output logic                       frame_start
);
   localparam int HTotal     = HVisible + HFront + HSync + HBack;
   localparam int VTotal     = VVisible + VFront + VSync + VBack;
   localparam int HSyncFirst = HVisible + HFront;
   localparam int HSyncLast  = HSyncFirst + HSync - 1;
   localparam int VSyncFirst = VVisible + VFront;
   localparam int VSyncLast  = VSyncFirst + VSync - 1;
   localparam int HW         = $clog2(HTotal);
   localparam int VW         = $clog2(VTotal);

   // Stage-1 flags travelling alongside the memory read.
   typedef struct packed {
      logic vis;
      logic hs;
      logic vs;
   } stage1_t;

   logic                 ph;
   logic                 tick;
   logic [HW-1:0]        hcount;
   logic [VW-1:0]        vcount;
   logic                 h_last, v_last;
   logic                 vis, hs_raw, vs_raw;
   stage1_t              d1;
   logic [ColorBits-1:0] pix;

   assign tick   = ph;
   assign clkVGA = ph;
   assign pix    = mem.readValueMemory;

   assign h_last = (hcount == HW'(HTotal - 1));
   assign v_last = (vcount == VW'(VTotal - 1));
   assign vis    = (hcount < HW'(HVisible)) && (vcount < VW'(VVisible));
   assign hs_raw = !((hcount >= HW'(HSyncFirst)) && (hcount <= HW'(HSyncLast)));
   assign vs_raw = !((vcount >= VW'(VSyncFirst)) && (vcount <= VW'(VSyncLast)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ph          <= 1'b0;
         hcount      <= '0;
         vcount      <= '0;
         mem.XRead   <= '0;
         mem.YRead   <= '0;
         d1          <= '{vis: 1'b0, hs: 1'b1, vs: 1'b1};
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         blank       <= 1'b0;
         red         <= '0;
         green       <= '0;
         blue        <= '0;
         frame_start <= 1'b0;
      end else begin
         ph          <= ~ph;
         frame_start <= 1'b0;
         if (tick) begin
            // scan counters
            if (h_last) begin
               hcount <= '0;
               vcount <= v_last ? '0 : vcount + 1'b1;
            end else begin
               hcount <= hcount + 1'b1;
            end
            // the wrap back to (0,0) is the start of a new frame; the
            // restart out of reset never passes here, so it gives no pulse
            frame_start <= h_last && v_last;

            // stage 1: canvas is half resolution; park the address at 0
            // during blanking
            mem.XRead <= vis ? 9'(hcount >> 1) : 9'd0;
            mem.YRead <= vis ? 8'(vcount >> 1) : 8'd0;
            d1        <= '{vis: vis, hs: hs_raw, vs: vs_raw};

            // stage 2: memory data for the stage-1 address is valid now
            hsync <= d1.hs;
            vsync <= d1.vs;
            blank <= d1.vis;
            red   <= (d1.vis && pix[2]) ? 8'hFF : 8'h00;
            green <= (d1.vis && pix[1]) ? 8'hFF : 8'h00;
            blue  <= (d1.vis && pix[0]) ? 8'hFF : 8'h00;
         end
      end
   end
endmodule

// File: tb/tb_pixel_scan_reader.sv
// Bench for pixel_scan_reader on a reduced screen geometry so whole frames
// fit in a short run. The reference model maps the n-th pixel tick since
// reset release to a linear scan position and derives every output from it.
module tb_pixel_scan_reader;
   localparam int HV = 16, HF = 2, HS = 4, HB = 3;
   localparam int VV = 12, VF = 2, VS = 2, VB = 3;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int F  = HT * VT;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       blank;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } vid_t;

   localparam vid_t RESET_VID = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, r: 8'h00, g: 8'h00, b: 8'h00};

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       hsync, vsync, blank, clkVGA, frame_start;
   logic [7:0] red, green, blue;

   pixel_scan_reader_if #(.ColorBits(3)) mem_if ();

   pixel_scan_reader #(
      .ColorBits(3),
      .HVisible(HV), .HFront(HF), .HSync(HS), .HBack(HB),
      .VVisible(VV), .VFront(VF), .VSync(VS), .VBack(VB)
   ) dut (
      .clk(clk), .reset(reset), .mem(mem_if),
      .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
      .blank(blank), .clkVGA(clkVGA), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int mode  = 0;   // 0 random canvas, 1 single spot, 2 all white
   logic [2:0] canvas [16][16];

   // scan statistics gathered by run_scan
   int fs_cnt, fs_first, fs_last, hs_low, vs_low, blank_hi, red_hi, green_hi, blue_hi;

   function automatic logic [2:0] mem_pix(input int x, input int y);
      case (mode)
         0:       return canvas[x % 16][y % 16];
         1:       return (x == 5 && y == 3) ? 3'b101 : 3'b000;
         default: return 3'b111;
      endcase
   endfunction

   // Canvas memory: correct data only becomes available 1 clk after the
   // address changes; every other clk it returns random junk.
   always @(posedge clk) begin
      #1;
      if (reset && clkVGA)
         mem_if.readValueMemory = mem_pix(int'(mem_if.XRead), int'(mem_if.YRead));
      else
         mem_if.readValueMemory = 3'($urandom);
   end

   // Expected video for linear scan position p.
   function automatic vid_t vid_model(input int p);
      int h, v;
      logic [2:0] px;
      vid_t o;
      h = p % HT;
      v = (p / HT) % VT;
      o.hs    = !(h >= HV + HF && h < HV + HF + HS);
      o.vs    = !(v >= VV + VF && v < VV + VF + VS);
      o.blank = (h < HV) && (v < VV);
      px      = o.blank ? mem_pix(h / 2, v / 2) : 3'b000;
      o.r     = px[2] ? 8'hFF : 8'h00;
      o.g     = px[1] ? 8'hFF : 8'h00;
      o.b     = px[0] ? 8'hFF : 8'h00;
      return o;
   endfunction

   task automatic restart();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Runs nclk clocks from a reset release, comparing every output after
   // every edge. After edge e, e/2 ticks have happened; the address shows
   // position ticks-1 and the video shows position ticks-2.
   task automatic run_scan(input int nclk);
      vid_t       ev;
      logic [8:0] ex;
      logic [7:0] ey;
      logic       ec_vga, ec_fs;
      int         k, p, h, v;
      fs_cnt = 0; fs_first = -1; fs_last = -1; hs_low = 0; vs_low = 0;
      blank_hi = 0; red_hi = 0; green_hi = 0; blue_hi = 0;
      for (int e = 1; e <= nclk; e++) begin
         @(posedge clk);
         #1;
         k      = e / 2;
         ec_vga = (e % 2) == 1;
         ec_fs  = (e % 2 == 0) && (k % F == 0);
         ex = '0; ey = '0;
         if (k >= 1) begin
            p = k - 1; h = p % HT; v = (p / HT) % VT;
            if (h < HV && v < VV) begin ex = 9'(h / 2); ey = 8'(v / 2); end
         end
         ev = (k >= 2) ? vid_model(k - 2) : RESET_VID;

         tests++;
         if ({clkVGA, frame_start} !== {ec_vga, ec_fs}) begin
            fails++;
            $display("FAIL ctrl e=%0d clkVGA,frame_start got %b%b exp %b%b", e, clkVGA, frame_start, ec_vga, ec_fs);
         end
         tests++;
         if ({mem_if.XRead, mem_if.YRead} !== {ex, ey}) begin
            fails++;
            $display("FAIL addr e=%0d X,Y got %0d,%0d exp %0d,%0d", e, mem_if.XRead, mem_if.YRead, ex, ey);
         end
         tests++;
         if ({hsync, vsync, blank, red, green, blue} !== ev) begin
            fails++;
            $display("FAIL video e=%0d hs,vs,blank,rgb got %b%b%b %h%h%h exp %b%b%b %h%h%h", e,
                     hsync, vsync, blank, red, green, blue, ev.hs, ev.vs, ev.blank, ev.r, ev.g, ev.b);
         end

         if (frame_start === 1'b1) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = k;
            fs_last = k;
         end
         if (e % 2 == 0 && k >= 2) begin
            if (hsync === 1'b0) hs_low++;
            if (vsync === 1'b0) vs_low++;
            if (blank === 1'b1) blank_hi++;
            if (red   === 8'hFF) red_hi++;
            if (green === 8'hFF) green_hi++;
            if (blue  === 8'hFF) blue_hi++;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({clkVGA, frame_start, mem_if.XRead, mem_if.YRead, hsync, vsync, blank, red, green, blue}
          !== {2'b00, 9'd0, 8'd0, RESET_VID}) begin
         fails++;
         $display("FAIL reset_state got clk/fs=%b%b X=%0d Y=%0d hs=%b vs=%b blank=%b rgb=%h%h%h",
                  clkVGA, frame_start, mem_if.XRead, mem_if.YRead, hsync, vsync, blank, red, green, blue);
      end
   endtask

   // Random canvas over two full frames; frame and sync totals.
   task automatic test_frames();
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            canvas[x][y] = 3'($urandom);
      mode = 0;
      restart();
      run_scan(2 * (2 * F + 1));
      tests++;
      if (fs_cnt != 2 || fs_first != F || fs_last - fs_first != F) begin
         fails++;
         $display("FAIL frame_pulses got cnt=%0d first=%0d gap=%0d exp 2,%0d,%0d", fs_cnt, fs_first, fs_last - fs_first, F, F);
      end
      tests++;
      if (hs_low != 2 * HS * VT || vs_low != 2 * VS * HT) begin
         fails++;
         $display("FAIL sync_totals got hs_low=%0d vs_low=%0d exp %0d %0d", hs_low, vs_low, 2 * HS * VT, 2 * VS * HT);
      end
   endtask

   task automatic test_spot();
      mode = 1;
      restart();
      run_scan(2 * (F + 1));
      tests++;
      if (red_hi != 4 || green_hi != 0 || blue_hi != 4) begin
         fails++;
         $display("FAIL spot_count got r=%0d g=%0d b=%0d exp 4 0 4", red_hi, green_hi, blue_hi);
      end
   endtask

   task automatic test_white();
      mode = 2;
      restart();
      run_scan(2 * (F + 1));
      tests++;
      if (blank_hi != HV * VV || red_hi != HV * VV) begin
         fails++;
         $display("FAIL white_count got blank=%0d red=%0d exp %0d", blank_hi, red_hi, HV * VV);
      end
   endtask

   // Reset mid-frame must clear everything without a clock edge, then the
   // restart must match a cold start.
   task automatic test_mid_reset();
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            canvas[x][y] = 3'($urandom);
      mode = 0;
      restart();
      run_scan(2 * (7 * HT + 11));
      #1 reset = 1'b0;
      #1;
      tests++;
      if ({clkVGA, frame_start, mem_if.XRead, mem_if.YRead, hsync, vsync, blank, red, green, blue}
          !== {2'b00, 9'd0, 8'd0, RESET_VID}) begin
         fails++;
         $display("FAIL async_reset got clk/fs=%b%b X=%0d Y=%0d hs=%b vs=%b blank=%b rgb=%h%h%h",
                  clkVGA, frame_start, mem_if.XRead, mem_if.YRead, hsync, vsync, blank, red, green, blue);
      end
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({clkVGA, mem_if.XRead, hsync, blank} !== {1'b0, 9'd0, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL reset_hold got clkVGA=%b X=%0d hs=%b blank=%b", clkVGA, mem_if.XRead, hsync, blank);
      end
      @(negedge clk);
      reset = 1'b1;
      run_scan(2 * (F + 1));
      tests++;
      if (fs_cnt != 1 || fs_first != F) begin
         fails++;
         $display("FAIL restart_frame got cnt=%0d first=%0d exp 1 %0d", fs_cnt, fs_first, F);
      end
   endtask

   initial begin
      test_reset();
      test_frames();
      test_spot();
      test_white();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not complete in time");
      $fatal(1, "timeout");
   end
endmodule
